fetch_sequencer: RTL and testbench

// - Controls the instruction-fetch stage. Owns the PC, issues req/ack fetches to instruction memory, and holds one fetched instruction for IF/ID.
// - Applies the two hazard stalls and branch redirects (next PC = PC+4 or PC+offset).
// - Sits between hazard/branch logic (EX/ID) and instmem. Replaces the free-running PC update with a handshake-aware sequence.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc_unit.sv | 34 +++
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        NEXT,
        DROP
    } fetch_state_t;

    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter register with its next-PC adder (sequential step or branch offset).
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc,
    input  logic          i_redir,
    input  logic [AW-1:0] i_offset,
    output logic [AW-1:0] o_pc
);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_step;
    logic [AW-1:0] w_pc_nxt;

    assign w_step   = AW'(PC_STEP);
    // Redirect wins over the sequential step; the sum wraps modulo 2^AW.
    assign w_pc_nxt = r_pc + (i_redir ? i_offset : w_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_inc || i_redir) begin
            r_pc <= w_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: req/ack handshake to instmem, one-entry IF/ID slot,
// hazard stalls, branch redirect with abandoned-fetch drop, and ack timeout flag.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC),
    parameter logic [31:0]   NOP      = NOP_INSN,
    parameter int unsigned   TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hazard_stall,
    input  logic          hazard_stall2,
    input  logic          br_taken,
    input  logic [AW-1:0] offset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   inst,
    output logic          inst_valid,
    output logic [AW-1:0] pc,
    output logic          err
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [31:0]   r_inst;
    logic          r_inst_valid;
    logic [7:0]    r_wait_cnt;
    logic          r_err;

    logic          w_stall;
    logic          w_consume;
    logic          w_slot_free;
    logic          w_req;
    logic          w_inc;
    logic          w_redir;
    logic          w_capture;
    logic          w_cnt_run;
    logic [AW-1:0] w_pc;

    assign w_stall     = hazard_stall | hazard_stall2;
    assign w_consume   = r_inst_valid & ~w_stall & ~br_taken;
    assign w_slot_free = ~r_inst_valid | w_consume;

    fetch_pc_unit #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_inc),
        .i_redir  (w_redir),
        .i_offset (offset),
        .o_pc     (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_inc       = 1'b0;
        w_redir     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                w_req = 1'b1;
                if (br_taken) begin
                    // An ack in the same cycle retires the old fetch, so no drop is needed.
                    w_redir     = 1'b1;
                    w_state_nxt = imem_ack ? FETCH : DROP;
                end else if (imem_ack) begin
                    w_capture   = 1'b1;
                    w_inc       = 1'b1;
                    w_state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (br_taken) begin
                    w_redir     = 1'b1;
                    w_state_nxt = FETCH;
                end else if (w_slot_free) begin
                    w_state_nxt = FETCH;
                end
            end
            DROP: begin
                if (br_taken) begin
                    w_redir = 1'b1;
                end else if (imem_ack) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
        end else if (w_redir || w_consume) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
        end else if (w_capture) begin
            r_inst       <= imem_rdata;
            r_inst_valid <= 1'b1;
        end
    end

    assign w_cnt_run = w_req & ~imem_ack & ~br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (imem_ack || br_taken) begin
                r_wait_cnt <= '0;
            end else if (w_cnt_run && (r_wait_cnt != C_TIMEOUT)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // Flag on the edge where the counter reaches TIMEOUT.
            if (w_cnt_run && (r_wait_cnt >= C_TIMEOUT - 8'd1)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = w_pc;
    assign pc         = w_pc;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign err        = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: scoreboard queues of expected fetch addresses
// and captured instructions, compared with immediate assertions.
module tb_fetch_sequencer;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hs = 1'b0;
    logic          hs2 = 1'b0;
    logic          br = 1'b0;
    logic [AW-1:0] off = '0;
    logic          ack = 1'b0;
    logic [31:0]   rdata = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   inst;
    logic          inst_valid;
    logic [AW-1:0] pc;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_inst[$];

    always #5 clk = ~clk;

    fetch_sequencer #(
        .AW       (AW),
        .RESET_PC (32'h0000_0000),
        .NOP      (32'h0000_0000),
        .TIMEOUT  (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hazard_stall  (hs),
        .hazard_stall2 (hs2),
        .br_taken      (br),
        .offset        (off),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (ack),
        .imem_rdata    (rdata),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .pc            (pc),
        .err           (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ack   = 1'b0;
        br    = 1'b0;
        hs    = 1'b0;
        hs2   = 1'b0;
        off   = '0;
        rdata = '0;
        #1;
        check_bit({tag, "_rst_req"}, imem_req, 1'b0);
        check({tag, "_rst_pc"}, pc, 32'h0);
        check({tag, "_rst_inst"}, inst, 32'h0);
        check_bit({tag, "_rst_vld"}, inst_valid, 1'b0);
        check_bit({tag, "_rst_err"}, err, 1'b0);
        q_addr.delete();
        q_inst.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Bounded wait for a request, then compare its address against the scoreboard.
    task automatic wait_req(input string tag, input int unsigned max_cycles);
        int unsigned k = 0;
        while (imem_req !== 1'b1 && k < max_cycles) begin
            tick();
            k++;
        end
        check_bit({tag, "_req"}, imem_req, 1'b1);
        if (q_addr.size() == 0) begin
            check({tag, "_sb_size"}, 32'(q_addr.size()), 32'h1);
        end else begin
            check({tag, "_addr"}, imem_addr, q_addr.pop_front());
        end
    endtask

    // Serve one fetch: ack arrives 'gap' cycles after the request is seen.
    task automatic fetch(input string tag, input int unsigned gap, input logic [31:0] data);
        logic [31:0] a;
        wait_req(tag, 8);
        a = imem_addr;
        repeat (gap - 1) begin
            tick();
            check_bit({tag, "_hold_req"}, imem_req, 1'b1);
            check({tag, "_hold_addr"}, imem_addr, a);
        end
        ack   = 1'b1;
        rdata = data;
        q_inst.push_back(data);
        tick();
        ack   = 1'b0;
        rdata = '0;
        check({tag, "_inst"}, inst, q_inst.pop_front());
        check_bit({tag, "_vld"}, inst_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Straight-line fetches, ack two cycles after each request.
        do_reset("init");
        check_bit("idle_req", imem_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            q_addr.push_back(32'(i * 4));
            fetch($sformatf("seq%0d", i), 2, 32'hA000_0000 + i);
            check($sformatf("seq%0d_pc", i), pc, 32'((i + 1) * 4));
        end

        // Stall on hazard_stall with a full slot.
        hs = 1'b1;
        repeat (3) begin
            tick();
            check_bit("st1_req", imem_req, 1'b0);
            check("st1_pc", pc, 32'h10);
            check("st1_inst", inst, 32'hA000_0003);
            check_bit("st1_vld", inst_valid, 1'b1);
        end
        hs = 1'b0;
        tick();
        check_bit("st1_rel_req", imem_req, 1'b1);
        check_bit("st1_rel_vld", inst_valid, 1'b0);
        check("st1_rel_inst", inst, 32'h0);
        q_addr.push_back(32'h10);
        fetch("st1_fetch", 2, 32'hB000_0001);
        check("st1_pc_after", pc, 32'h14);

        // Same again on hazard_stall2.
        hs2 = 1'b1;
        repeat (3) begin
            tick();
            check_bit("st2_req", imem_req, 1'b0);
            check("st2_pc", pc, 32'h14);
            check("st2_inst", inst, 32'hB000_0001);
            check_bit("st2_vld", inst_valid, 1'b1);
        end
        hs2 = 1'b0;
        tick();
        check_bit("st2_rel_req", imem_req, 1'b1);
        q_addr.push_back(32'h14);
        fetch("st2_fetch", 2, 32'hB000_0002);
        check("st2_pc_after", pc, 32'h18);

        // Branch while the fetch at pc=8 is outstanding.
        do_reset("br");
        q_addr.push_back(32'h0);
        fetch("br_f0", 2, 32'hC000_0000);
        q_addr.push_back(32'h4);
        fetch("br_f1", 2, 32'hC000_0004);
        q_addr.push_back(32'h8);
        wait_req("br_pre", 4);
        br  = 1'b1;
        off = 32'h20;
        tick();
        br  = 1'b0;
        off = '0;
        check_bit("drop_req", imem_req, 1'b0);
        check_bit("drop_vld", inst_valid, 1'b0);
        check("drop_pc", pc, 32'h28);
        check("drop_inst", inst, 32'h0);
        tick();
        check_bit("drop_req2", imem_req, 1'b0);
        ack   = 1'b1;
        rdata = 32'hDEAD_BEEF;
        tick();
        ack   = 1'b0;
        rdata = '0;
        check("drop_discard_inst", inst, 32'h0);
        check_bit("drop_discard_vld", inst_valid, 1'b0);
        check_bit("drop_refetch_req", imem_req, 1'b1);
        check("drop_refetch_addr", imem_addr, 32'h28);

        // Branch on the same cycle as the ack.
        ack   = 1'b1;
        rdata = 32'h1234_5678;
        br    = 1'b1;
        off   = 32'h10;
        tick();
        ack   = 1'b0;
        rdata = '0;
        br    = 1'b0;
        off   = '0;
        check_bit("brack_req", imem_req, 1'b1);
        check("brack_addr", imem_addr, 32'h38);
        check("brack_inst", inst, 32'h0);
        check_bit("brack_vld", inst_valid, 1'b0);
        q_addr.push_back(32'h38);
        fetch("brack_next", 1, 32'hC0DE_0001);
        check("brack_pc", pc, 32'h3C);

        // Branch and stall together; negative offset wraps below zero.
        do_reset("bs");
        q_addr.push_back(32'h0);
        fetch("bs_f0", 2, 32'hD000_0000);
        check("bs_pc", pc, 32'h4);
        hs  = 1'b1;
        br  = 1'b1;
        off = 32'hFFFF_FFF8;
        tick();
        hs  = 1'b0;
        br  = 1'b0;
        off = '0;
        check_bit("bs_req", imem_req, 1'b1);
        check("bs_addr", imem_addr, 32'hFFFF_FFFC);
        check_bit("bs_vld", inst_valid, 1'b0);
        check("bs_inst", inst, 32'h0);

        // Ack withheld: err must appear on the 15th waiting cycle, not the 14th.
        repeat (14) tick();
        check_bit("to_before", err, 1'b0);
        tick();
        check_bit("to_reached", err, 1'b1);
        repeat (5) tick();
        check_bit("to_hold_err", err, 1'b1);
        check_bit("to_hold_req", imem_req, 1'b1);
        check("to_hold_addr", imem_addr, 32'hFFFF_FFFC);
        ack   = 1'b1;
        rdata = 32'hABCD_0001;
        q_inst.push_back(32'hABCD_0001);
        tick();
        ack   = 1'b0;
        rdata = '0;
        check("to_inst", inst, q_inst.pop_front());
        check_bit("to_vld", inst_valid, 1'b1);
        check("to_pc_wrap", pc, 32'h0);
        check_bit("to_err_after_ack", err, 1'b1);
        tick();
        check_bit("to_sticky", err, 1'b1);

        // Reset pulse in the middle of a fetch.
        q_addr.push_back(32'h0);
        fetch("rm_f0", 1, 32'hE000_0000);
        q_addr.push_back(32'h4);
        wait_req("rm_pre", 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("rm_req", imem_req, 1'b0);
        check("rm_pc", pc, 32'h0);
        check("rm_inst", inst, 32'h0);
        check_bit("rm_vld", inst_valid, 1'b0);
        check_bit("rm_err", err, 1'b0);
        tick();
        rst_n = 1'b1;
        ack   = 1'b1;
        rdata = 32'h55AA_55AA;
        tick();
        ack   = 1'b0;
        rdata = '0;
        check("rm_late_inst", inst, 32'h0);
        check_bit("rm_late_vld", inst_valid, 1'b0);
        q_addr.push_back(32'h0);
        fetch("rm_post", 2, 32'h0F0F_0F0F);
        check("rm_post_pc", pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
